// File: rtl/imem_ctrl.sv
// Instruction-memory controller: arbitrates the single-port program BRAM between
// the serial program loader (LOAD) and CPU instruction fetch (RUN).
module imem_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_sel,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              load_last,
  output logic              load_gnt,
  output logic [ADDR_W:0]   load_cnt,
  output logic              cpu_hold,
  output logic              err_misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [ADDR_W:0] LastIdx = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              fetch_valid_q;
  logic              err_misalign_q, err_misalign_d;

  // Byte-address bits above the BRAM depth are dropped, so fetches wrap.
  logic unused_fetch_addr;
  assign unused_fetch_addr = ^fetch_addr[31:ADDR_W+2];

  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    err_misalign_d = err_misalign_q;
    fetch_gnt      = 1'b0;
    load_gnt       = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state_q)
      StIdle: state_d = boot_sel ? StLoad : StRun;

      StLoad: begin
        load_gnt = load_req;
        if (load_req) begin
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = load_cnt_q[ADDR_W-1:0];
          mem_wdata  = load_wdata;
          load_cnt_d = load_cnt_q + CntOne;
          // Stop at the last word or when the top address is written; never wrap.
          if (load_last || (load_cnt_q == LastIdx)) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (reload) begin
          state_d    = StLoad;
          load_cnt_d = '0;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = fetch_addr[ADDR_W+1:2];
          if (fetch_addr[1:0] != 2'b00) begin
            err_misalign_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    cpu_hold_d = (state_d != StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      load_cnt_q     <= '0;
      cpu_hold_q     <= 1'b1;
      fetch_valid_q  <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      cpu_hold_q     <= cpu_hold_d;
      fetch_valid_q  <= fetch_gnt;
      err_misalign_q <= err_misalign_d;
    end
  end

  assign load_cnt     = load_cnt_q;
  assign cpu_hold     = cpu_hold_q;
  assign fetch_valid  = fetch_valid_q;
  assign err_misalign = err_misalign_q;
  assign fetch_data   = mem_rdata;

endmodule
